video_sdram_arbiter: RTL and testbench

VIDEO_SDRAM_ARBITER -- requirements
Module: video_sdram_arbiter

---
 rtl/video_arb_pkg.sv | 15 +
 rtl/arb_toggle_port.sv | 28 ++
 rtl/video_sdram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_video_sdram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_arb_pkg.sv
// Shared types and constants for the video/CPU SDRAM arbiter.
package video_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam logic [1:0] PORT_VO  = 2'd0;
  localparam logic [1:0] PORT_VI  = 2'd1;
  localparam logic [1:0] PORT_CPU = 2'd2;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_toggle_port.sv
// One toggle-handshake requester: holds the ack register and derives pending.
module arb_toggle_port (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_i,
  input  logic done_i,
  output logic ack_o,
  output logic pending_o
);

  logic ack_q, ack_d;

  // Ack follows req on completion, so a stray second toggle during service
  // cancels itself instead of leaving a phantom request behind.
  always_comb begin
    ack_d = ack_q;
    if (done_i) ack_d = req_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ack_q <= 1'b0;
    else         ack_q <= ack_d;
  end

  assign ack_o     = ack_q;
  assign pending_o = req_i ^ ack_q;

endmodule

// File: rtl/video_sdram_arbiter.sv
// Three-port SDRAM arbiter (video read, video write, CPU) with CPU anti-starvation,
// single outstanding transaction on a toggle-handshake controller port.
module video_sdram_arbiter
  import video_arb_pkg::*;
#(
  parameter int ADDR_W       = 23,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vo_req,
  input  logic [ADDR_W-1:0] vo_addr,
  output logic [15:0]       vo_q,
  output logic              vo_ack,
  input  logic              vi_req,
  input  logic [ADDR_W-1:0] vi_addr,
  input  logic [15:0]       vi_d,
  output logic              vi_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_ds,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_ds,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_ack
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  arb_state_e          state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]          mem_ds_q, mem_ds_d;
  logic [15:0]         mem_din_q, mem_din_d;
  logic [15:0]         vo_data_q, vo_data_d;
  logic [15:0]         cpu_data_q, cpu_data_d;

  logic [2:0] req_vec, done_vec, ack_vec, pend_vec;
  logic [1:0] sel;
  logic       any_pend;

  assign req_vec[PORT_VO]  = vo_req;
  assign req_vec[PORT_VI]  = vi_req;
  assign req_vec[PORT_CPU] = cpu_req;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
      arb_toggle_port u_port (
        .clk_i     (clk_sys),
        .reset_i   (reset),
        .req_i     (req_vec[gi]),
        .done_i    (done_vec[gi]),
        .ack_o     (ack_vec[gi]),
        .pending_o (pend_vec[gi])
      );
    end
  endgenerate

  assign any_pend = |pend_vec;

  // Fixed priority vo > vi > cpu, overridden once the CPU has waited out STARVE_LIMIT grants.
  always_comb begin
    sel = PORT_VI;
    if (pend_vec[PORT_CPU] &&
        (starve_q == STARVE_MAX || !(pend_vec[PORT_VO] || pend_vec[PORT_VI])))
      sel = PORT_CPU;
    else if (pend_vec[PORT_VO])
      sel = PORT_VO;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    starve_d   = starve_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_ds_d   = mem_ds_q;
    mem_din_d  = mem_din_q;
    vo_data_d  = vo_data_q;
    cpu_data_d = cpu_data_q;
    done_vec   = 3'b000;
    case (state_q)
      IDLE: begin
        if (!pend_vec[PORT_CPU]) starve_d = '0;
        if (any_pend) begin
          state_d   = WAIT;
          grant_d   = sel;
          mem_req_d = ~mem_req_q;
          case (sel)
            PORT_VO: begin
              mem_we_d   = 1'b0;
              mem_ds_d   = 2'b11;
              mem_addr_d = vo_addr;
            end
            PORT_VI: begin
              mem_we_d   = 1'b1;
              mem_ds_d   = 2'b11;
              mem_addr_d = vi_addr;
              mem_din_d  = vi_d;
            end
            default: begin
              mem_we_d   = cpu_we;
              mem_ds_d   = cpu_ds;
              mem_addr_d = cpu_addr;
              mem_din_d  = cpu_din;
            end
          endcase
          if (sel == PORT_CPU)
            starve_d = '0;
          else if (pend_vec[PORT_CPU] && starve_q != STARVE_MAX)
            starve_d = starve_q + STARVE_ONE;
        end
      end
      default: begin
        if (mem_ack == mem_req_q) begin
          state_d = IDLE;
          case (grant_q)
            PORT_VO: begin
              done_vec[PORT_VO] = 1'b1;
              if (!mem_we_q) vo_data_d = mem_dout;
            end
            PORT_VI: done_vec[PORT_VI] = 1'b1;
            default: begin
              done_vec[PORT_CPU] = 1'b1;
              if (!mem_we_q) cpu_data_d = mem_dout;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= PORT_VO;
      starve_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_ds_q   <= 2'b00;
      mem_din_q  <= '0;
      vo_data_q  <= '0;
      cpu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      starve_q   <= starve_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_ds_q   <= mem_ds_d;
      mem_din_q  <= mem_din_d;
      vo_data_q  <= vo_data_d;
      cpu_data_q <= cpu_data_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_ds   = mem_ds_q;
  assign mem_din  = mem_din_q;
  assign vo_q     = vo_data_q;
  assign cpu_dout = cpu_data_q;
  assign vo_ack   = ack_vec[PORT_VO];
  assign vi_ack   = ack_vec[PORT_VI];
  assign cpu_ack  = ack_vec[PORT_CPU];

endmodule

// File: tb/tb_video_sdram_arbiter.sv
// Directed bench for video_sdram_arbiter with a simple latency-programmable SDRAM responder.
module tb_video_sdram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        vo_req  = 1'b0;
  logic [22:0] vo_addr = '0;
  logic [15:0] vo_q;
  logic        vo_ack;
  logic        vi_req  = 1'b0;
  logic [22:0] vi_addr = '0;
  logic [15:0] vi_d    = '0;
  logic        vi_ack;
  logic        cpu_req = 1'b0;
  logic        cpu_we  = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [1:0]  cpu_ds  = 2'b11;
  logic [15:0] cpu_din = '0;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic        mem_req, mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_ack  = 1'b0;

  int          mem_lat   = 3;
  logic [15:0] mem_rdata = '0;
  int          lat_cnt   = 0;
  int          n_cmp     = 0;
  int          n_bad     = 0;

  video_sdram_arbiter #(.ADDR_W(23), .STARVE_LIMIT(4)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vo_req(vo_req), .vo_addr(vo_addr), .vo_q(vo_q), .vo_ack(vo_ack),
    .vi_req(vi_req), .vi_addr(vi_addr), .vi_d(vi_d), .vi_ack(vi_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ds(mem_ds),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  // Controller model: answers mem_ack (with mem_rdata) mem_lat full cycles after mem_req toggles.
  always @(posedge clk_sys) begin
    #1;
    if (reset) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (mem_req != mem_ack) begin
      lat_cnt++;
      if (lat_cnt > mem_lat) begin
        mem_ack  = mem_req;
        mem_dout = mem_rdata;
        lat_cnt  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic wait_grant(input string tag);
    logic prev;
    int   n;
    prev = mem_req;
    n    = 0;
    while (mem_req == prev && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_grant"}, 32'(mem_req != prev), 32'd1);
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while ((vo_ack != vo_req || vi_ack != vi_req || cpu_ack != cpu_req) && n < 300) begin
      tick();
      n++;
    end
    tick();
    chk({tag, "_quiet"}, 32'(vo_ack == vo_req && vi_ack == vi_req && cpu_ack == cpu_req), 32'd1);
  endtask

  int         n;
  int         ngr;
  logic [1:0] ports [10];
  logic       prev_req;
  logic       cpu_second;

  initial begin
    // reset state
    tick(); tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_acks", {29'd0, vo_ack, vi_ack, cpu_ack}, 32'd0);
    chk("rst_mem_we_ds", {29'd0, mem_we, mem_ds}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_rdata", {vo_q, cpu_dout}, 32'd0);
    reset = 1'b0;
    tick();

    // single vo read, 3-cycle controller latency, addr change during WAIT
    vo_addr   = 23'h000100;
    mem_rdata = 16'hBEEF;
    mem_lat   = 3;
    vo_req    = ~vo_req;
    tick();
    chk("vo_memreq_lat1", 32'(mem_req), 32'd1);
    chk("vo_mem_addr", 32'(mem_addr), 32'h100);
    chk("vo_mem_we_ds", {29'd0, mem_we, mem_ds}, 32'h3);
    vo_addr = 23'h0003FF;
    n = 0;
    while (mem_ack != mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("vo_memack_lat", 32'(n), 32'd3);
    chk("vo_ack_not_early", 32'(vo_ack), 32'd0);
    chk("vo_addr_held", 32'(mem_addr), 32'h100);
    tick();
    chk("vo_ack_lat1", 32'(vo_ack), 32'd1);
    chk("vo_q_beef", 32'(vo_q), 32'hBEEF);

    // extra vo toggle while in service: no leftover pending, no extra transaction
    vo_addr   = 23'h000077;
    mem_rdata = 16'h2468;
    vo_req    = ~vo_req;
    wait_grant("viol");
    tick();
    vo_req = ~vo_req;
    n = 0;
    while (mem_ack != mem_req && n < 20) begin
      tick();
      n++;
    end
    tick(); tick();
    chk("viol_no_pending", 32'(vo_ack ^ vo_req), 32'd0);
    chk("viol_vo_q", 32'(vo_q), 32'h2468);
    prev_req = mem_req;
    for (int i = 0; i < 6; i++) tick();
    chk("viol_no_extra_txn", 32'(mem_req), 32'(prev_req));

    // reset while vi write is in service, vi_req held high across reset
    vi_addr = 23'h000042;
    vi_d    = 16'h9999;
    mem_lat = 10;
    vi_req  = 1'b1;
    wait_grant("rst_vi");
    chk("rst_vi_inflight", 32'(mem_req), 32'd1);
    tick(); tick();
    reset   = 1'b1;
    vo_req  = 1'b0;
    cpu_req = 1'b0;
    tick();
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_vi_ack", 32'(vi_ack), 32'd0);
    chk("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    reset   = 1'b0;
    mem_lat = 3;
    tick();
    chk("post_rst_grant", 32'(mem_req), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'h42);
    chk("post_rst_we_din", {15'd0, mem_we, mem_din}, 32'h1_9999);
    wait_quiet("post_rst");
    chk("post_rst_vi_ack", 32'(vi_ack), 32'd1);

    // simultaneous requests: vo, then vi, then cpu
    vo_addr   = 23'h000010;
    vi_addr   = 23'h000020;
    vi_d      = 16'h1234;
    cpu_addr  = 23'h000030;
    cpu_we    = 1'b0;
    cpu_ds    = 2'b11;
    mem_rdata = 16'h1111;
    vo_req    = ~vo_req;
    vi_req    = ~vi_req;
    cpu_req   = ~cpu_req;
    wait_grant("ord1");
    chk("ord1_addr_we", {8'd0, mem_we, mem_addr}, 32'h000010);
    wait_grant("ord2");
    chk("ord2_addr_we", {8'd0, mem_we, mem_addr}, 32'h800020);
    chk("ord2_din", 32'(mem_din), 32'h1234);
    chk("ord2_vo_done", 32'(vo_ack == vo_req), 32'd1);
    chk("ord2_vo_q", 32'(vo_q), 32'h1111);
    mem_rdata = 16'hC0DE;
    wait_grant("ord3");
    chk("ord3_addr_we", {8'd0, mem_we, mem_addr}, 32'h000030);
    chk("ord3_vi_done", 32'(vi_ack == vi_req), 32'd1);
    chk("ord3_vo_q_kept", 32'(vo_q), 32'h1111);
    wait_quiet("ord");
    chk("ord_cpu_dout", 32'(cpu_dout), 32'hC0DE);

    // starvation: video re-requests continuously, cpu gets every 5th grant
    vo_addr   = 23'h000001;
    vi_addr   = 23'h000002;
    cpu_addr  = 23'h000055;
    mem_rdata = 16'h5A5A;
    vo_req    = ~vo_req;
    vi_req    = ~vi_req;
    cpu_req   = ~cpu_req;
    cpu_second = 1'b0;
    ngr      = 0;
    prev_req = mem_req;
    for (int c = 0; c < 600 && ngr < 10; c++) begin
      tick();
      if (mem_req != prev_req) begin
        prev_req = mem_req;
        ports[ngr] = (mem_addr == 23'h55) ? 2'd2 : (mem_addr == 23'h2) ? 2'd1 : 2'd0;
        ngr++;
      end
      if (vo_ack == vo_req) vo_req = ~vo_req;
      if (vi_ack == vi_req) vi_req = ~vi_req;
      if (!cpu_second && cpu_ack == cpu_req) begin
        cpu_req    = ~cpu_req;
        cpu_second = 1'b1;
      end
    end
    chk("starve_grants", 32'(ngr), 32'd10);
    chk("starve_first4_video", 32'({ports[0] == 2'd2, ports[1] == 2'd2, ports[2] == 2'd2, ports[3] == 2'd2}), 32'd0);
    chk("starve_5th_cpu", 32'(ports[4]), 32'd2);
    chk("starve_next4_video", 32'({ports[5] == 2'd2, ports[6] == 2'd2, ports[7] == 2'd2, ports[8] == 2'd2}), 32'd0);
    chk("starve_10th_cpu", 32'(ports[9]), 32'd2);
    wait_quiet("starve");
    chk("starve_cpu_dout", 32'(cpu_dout), 32'h5A5A);

    // cpu byte write at top address
    mem_rdata = 16'hFFFF;
    cpu_we    = 1'b1;
    cpu_ds    = 2'b01;
    cpu_din   = 16'h00A5;
    cpu_addr  = 23'h7FFFFF;
    cpu_req   = ~cpu_req;
    wait_grant("cpuwr");
    chk("cpuwr_addr", 32'(mem_addr), 32'h7FFFFF);
    chk("cpuwr_we_ds", {29'd0, mem_we, mem_ds}, 32'h5);
    chk("cpuwr_din", 32'(mem_din), 32'h00A5);
    wait_quiet("cpuwr");
    chk("cpuwr_dout_kept", 32'(cpu_dout), 32'h5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
